// File: rtl/arg_store_scanner_pkg.sv
// Shared types for the successor argument store and its column scanner.
package arg_store_pkg;

   localparam int DEF_ARG_ROW_WIDTH  = 3;
   localparam int DEF_ARG_COL_WIDTH  = 10;
   localparam int DEF_ARG_DATA_WIDTH = 16;
   localparam int DEF_NUM_ROWS       = 4;

   typedef logic [DEF_ARG_ROW_WIDTH-1:0]  arg_row_t;
   typedef logic [DEF_ARG_COL_WIDTH-1:0]  arg_col_t;
   typedef logic [DEF_ARG_DATA_WIDTH-1:0] arg_data_t;

   // IDLE accepts writes/clear; READ issues the RAM read; HOLD presents a beat;
   // DONE pulses scan_done for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } scan_state_t;

endpackage

// File: rtl/arg_store_scanner_if.sv
// Write bus, scan control and column-beat stream of the argument store.
// master = decoder/solver side, slave = the store itself.
interface arg_store_scanner_if #(
   parameter int ARG_ROW_WIDTH  = 3,
   parameter int ARG_COL_WIDTH  = 10,
   parameter int ARG_DATA_WIDTH = 16,
   parameter int NUM_ROWS       = 4
);
   logic                               wr_arg_valid;
   logic [ARG_ROW_WIDTH-1:0]           wr_arg_row;
   logic [ARG_COL_WIDTH-1:0]           wr_arg_col;
   logic [ARG_DATA_WIDTH-1:0]          wr_arg_data;
   logic                               wr_drop;
   logic                               clear;
   logic                               scan_start;
   logic                               scan_busy;
   logic                               out_valid;
   logic                               out_ready;
   logic [ARG_COL_WIDTH-1:0]           out_col;
   logic [NUM_ROWS*ARG_DATA_WIDTH-1:0] out_data;
   logic [NUM_ROWS-1:0]                out_row_mask;
   logic                               out_last;
   logic                               scan_done;

   modport master (
      output wr_arg_valid, wr_arg_row, wr_arg_col, wr_arg_data, clear, scan_start, out_ready,
      input  wr_drop, scan_busy, out_valid, out_col, out_data, out_row_mask, out_last, scan_done
   );

   modport slave (
      input  wr_arg_valid, wr_arg_row, wr_arg_col, wr_arg_data, clear, scan_start, out_ready,
      output wr_drop, scan_busy, out_valid, out_col, out_data, out_row_mask, out_last, scan_done
   );
endinterface

// File: rtl/arg_store_scanner_bank.sv
// One row of argument storage: simple dual-port RAM with registered read.
// Deliberately reset-free so it maps onto block RAM.
module arg_store_bank #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_reg;

   // Write port and registered read port; read data holds between reads.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;
endmodule

// File: rtl/arg_store_scanner.sv
// Successor argument store: sparse writes from the decoder, then columns
// 0..max_col streamed out (all rows in parallel) to the per-column solver.
module arg_store_scanner
   import arg_store_pkg::*;
#(
   parameter int ARG_ROW_WIDTH  = DEF_ARG_ROW_WIDTH,
   parameter int ARG_COL_WIDTH  = DEF_ARG_COL_WIDTH,
   parameter int ARG_DATA_WIDTH = DEF_ARG_DATA_WIDTH,
   parameter int NUM_ROWS       = DEF_NUM_ROWS
) (
   input  logic            clk,
   input  logic            rst_n,
   arg_store_scanner_if.slave bus
);
   localparam int DEPTH = 2**ARG_COL_WIDTH;
   localparam logic [ARG_ROW_WIDTH:0] ROW_LIMIT = (ARG_ROW_WIDTH+1)'(NUM_ROWS);

   scan_state_t              state_reg, state_next;
   logic [ARG_COL_WIDTH-1:0] col_reg, col_next;
   logic [ARG_COL_WIDTH-1:0] max_col_reg, max_col_next;
   logic                     any_written_reg, any_written_next;
   logic                     wr_drop_reg;
   logic                     is_idle;
   logic                     wr_accept;
   logic                     clear_accept;
   logic                     rd_en;
   logic                     at_max_col;

   assign is_idle      = (state_reg == IDLE);
   assign wr_accept    = bus.wr_arg_valid && is_idle && ({1'b0, bus.wr_arg_row} < ROW_LIMIT);
   assign clear_accept = bus.clear && is_idle;
   assign at_max_col   = (col_reg == max_col_reg);

   // Highest written column and "anything written" flag; clear applies before a same-cycle write.
   always_comb begin
      max_col_next     = max_col_reg;
      any_written_next = any_written_reg;
      if (clear_accept) begin
         max_col_next     = '0;
         any_written_next = 1'b0;
      end
      if (wr_accept) begin
         any_written_next = 1'b1;
         if (clear_accept || (bus.wr_arg_col > max_col_reg))
            max_col_next = bus.wr_arg_col;
      end
   end

   // Scan sequencing; the column counter stops at max_col so it never wraps.
   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      rd_en      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.scan_start) begin
               col_next   = '0;
               state_next = any_written_reg ? READ : DONE;
            end
         end
         READ: begin
            rd_en      = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               if (at_max_col) begin
                  state_next = DONE;
               end else begin
                  col_next   = col_reg + 1'b1;
                  state_next = READ;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         col_reg         <= '0;
         max_col_reg     <= '0;
         any_written_reg <= 1'b0;
         wr_drop_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         col_reg         <= col_next;
         max_col_reg     <= max_col_next;
         any_written_reg <= any_written_next;
         wr_drop_reg     <= bus.wr_arg_valid && !wr_accept;
      end
   end

   assign bus.wr_drop   = wr_drop_reg;
   assign bus.scan_busy = (state_reg == READ) || (state_reg == HOLD);
   assign bus.out_valid = (state_reg == HOLD);
   assign bus.out_last  = (state_reg == HOLD) && at_max_col;
   assign bus.scan_done = (state_reg == DONE);
   assign bus.out_col   = col_reg;

   generate
      for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : gen_row
         logic [DEPTH-1:0]          occ_row_reg;
         logic                      mask_bit_reg;
         logic                      wr_en_row;
         logic [ARG_DATA_WIDTH-1:0] rd_data;

         assign wr_en_row = wr_accept && (bus.wr_arg_row == ARG_ROW_WIDTH'(gi));

         arg_store_bank #(
            .ADDR_WIDTH (ARG_COL_WIDTH),
            .DATA_WIDTH (ARG_DATA_WIDTH)
         ) u_bank (
            .clk     (clk),
            .wr_en   (wr_en_row),
            .wr_addr (bus.wr_arg_col),
            .wr_data (bus.wr_arg_data),
            .rd_en   (rd_en),
            .rd_addr (col_reg),
            .rd_data (rd_data)
         );

         // Occupancy flops, and the mask bit captured alongside the RAM read.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               occ_row_reg  <= '0;
               mask_bit_reg <= 1'b0;
            end else begin
               if (clear_accept)
                  occ_row_reg <= '0;
               if (wr_en_row)
                  occ_row_reg[bus.wr_arg_col] <= 1'b1;
               if (rd_en)
                  mask_bit_reg <= occ_row_reg[col_reg];
            end
         end

         // Unwritten cells read as zero regardless of stale RAM contents.
         assign bus.out_row_mask[gi] = mask_bit_reg;
         assign bus.out_data[gi*ARG_DATA_WIDTH +: ARG_DATA_WIDTH] = mask_bit_reg ? rd_data : '0;
      end
   endgenerate
endmodule

// File: tb/tb_arg_store_scanner.sv
// Directed bench for arg_store_scanner with a scoreboard of expected beats.
module tb_arg_store_scanner;
   localparam int RW = 3;
   localparam int CW = 10;
   localparam int DW = 16;
   localparam int NR = 4;

   typedef struct {
      logic [CW-1:0]    col;
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    mask;
      logic             last;
   } beat_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   beat_t exp_q[$];

   arg_store_scanner_if #(.ARG_ROW_WIDTH(RW), .ARG_COL_WIDTH(CW),
                          .ARG_DATA_WIDTH(DW), .NUM_ROWS(NR)) bus ();

   arg_store_scanner #(.ARG_ROW_WIDTH(RW), .ARG_COL_WIDTH(CW),
                       .ARG_DATA_WIDTH(DW), .NUM_ROWS(NR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input int col, input logic [63:0] data, input logic [3:0] mask,
                            input logic last);
      beat_t b;
      b.col  = CW'(col);
      b.data = data;
      b.mask = mask;
      b.last = last;
      exp_q.push_back(b);
   endtask

   // Monitor: every accepted beat is compared against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got col %0d expected no beat", bus.out_col);
         end else begin
            beat_t b;
            b = exp_q.pop_front();
            check("beat_col", 64'(bus.out_col), 64'(b.col));
            check("beat_data", bus.out_data, b.data);
            check("beat_mask", 64'(bus.out_row_mask), 64'(b.mask));
            check("beat_last", 64'(bus.out_last), 64'(b.last));
            $display("beat col=%0d data=%h mask=%b last=%0d", bus.out_col, bus.out_data,
                     bus.out_row_mask, bus.out_last);
         end
      end
   end

   task automatic do_write(input int row, input int col, input int data, input logic clr,
                           input logic exp_drop);
      @(posedge clk);
      #1;
      bus.wr_arg_valid = 1'b1;
      bus.wr_arg_row   = RW'(row);
      bus.wr_arg_col   = CW'(col);
      bus.wr_arg_data  = DW'(data);
      bus.clear        = clr;
      @(posedge clk);
      #1;
      bus.wr_arg_valid = 1'b0;
      bus.clear        = 1'b0;
      @(negedge clk);
      check("wr_drop", 64'(bus.wr_drop), 64'(exp_drop));
      $display("write row=%0d col=%0d data=%0h clear=%0d drop=%0d", row, col, data, clr, bus.wr_drop);
   endtask

   task automatic start_scan();
      @(posedge clk);
      #1 bus.scan_start = 1'b1;
      @(posedge clk);
      #1 bus.scan_start = 1'b0;
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1 bus.out_ready = r;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid_timeout", 64'(bus.out_valid), 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.scan_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("scan_done_seen", 64'(bus.scan_done), 64'd1);
      @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("busy_after_done", 64'(bus.scan_busy), 64'd0);
   endtask

   task automatic push_t2_beats();
      push_beat(0, 64'h0000_0000_0007_0005, 4'b0011, 1'b0);
      push_beat(1, 64'h0, 4'b0000, 1'b0);
      push_beat(2, 64'h0000_0009_0000_0000, 4'b0100, 1'b1);
   endtask

   initial begin
      logic [CW-1:0]    held_col;
      logic [NR*DW-1:0] held_data;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.wr_arg_valid = 1'b0;
      bus.wr_arg_row   = '0;
      bus.wr_arg_col   = '0;
      bus.wr_arg_data  = '0;
      bus.clear        = 1'b0;
      bus.scan_start   = 1'b0;
      bus.out_ready    = 1'b1;

      // 1: reset values, then an empty scan finishes immediately
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_scan_busy", 64'(bus.scan_busy), 64'd0);
      check("rst_scan_done", 64'(bus.scan_done), 64'd0);
      check("rst_wr_drop", 64'(bus.wr_drop), 64'd0);
      check("rst_out_data", bus.out_data, 64'd0);
      check("rst_out_mask", 64'(bus.out_row_mask), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_out_col", 64'(bus.out_col), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      start_scan();
      @(negedge clk);
      check("empty_scan_done", 64'(bus.scan_done), 64'd1);
      check("empty_out_valid", 64'(bus.out_valid), 64'd0);
      check("empty_scan_busy", 64'(bus.scan_busy), 64'd0);
      @(negedge clk);
      check("empty_done_pulse", 64'(bus.scan_done), 64'd0);
      $display("test1 empty scan done");

      // 2: sparse writes, full-rate scan with latency check
      do_write(0, 0, 5, 1'b0, 1'b0);
      do_write(1, 0, 7, 1'b0, 1'b0);
      do_write(2, 2, 9, 1'b0, 1'b0);
      push_t2_beats();
      start_scan();
      @(negedge clk);
      check("lat_read_valid", 64'(bus.out_valid), 64'd0);
      check("lat_read_busy", 64'(bus.scan_busy), 64'd1);
      @(negedge clk);
      check("lat_hold_valid", 64'(bus.out_valid), 64'd1);
      wait_done();
      $display("test2 sparse scan done");

      // 3: backpressure holds the beat steady
      push_t2_beats();
      set_ready(1'b0);
      start_scan();
      wait_valid();
      held_col  = bus.out_col;
      held_data = bus.out_data;
      check("bp_first_col", 64'(held_col), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid_held", 64'(bus.out_valid), 64'd1);
         check("bp_col_held", 64'(bus.out_col), 64'(held_col));
         check("bp_data_held", bus.out_data, held_data);
      end
      set_ready(1'b1);
      wait_done();
      $display("test3 backpressure done");

      // 4: bad row and write during scan are dropped
      do_write(5, 0, 16'h1234, 1'b0, 1'b1);
      push_t2_beats();
      set_ready(1'b0);
      start_scan();
      wait_valid();
      do_write(1, 1, 16'h0055, 1'b0, 1'b1);
      set_ready(1'b1);
      wait_done();
      $display("test4 dropped writes done");

      // 5: clear with same-cycle write
      do_write(3, 10, 1, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++)
         push_beat(c, 64'h0, 4'b0000, 1'b0);
      push_beat(10, 64'h0001_0000_0000_0000, 4'b1000, 1'b1);
      start_scan();
      wait_done();
      $display("test5 clear+write done");

      // 6: asynchronous reset while holding column 1
      do_write(0, 0, 3, 1'b1, 1'b0);
      do_write(0, 3, 4, 1'b0, 1'b0);
      push_beat(0, 64'h0000_0000_0000_0003, 4'b0001, 1'b0);
      set_ready(1'b0);
      start_scan();
      wait_valid();
      set_ready(1'b1);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      wait_valid();
      check("rst6_col", 64'(bus.out_col), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst6_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst6_scan_busy", 64'(bus.scan_busy), 64'd0);
      check("rst6_scoreboard", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      start_scan();
      @(negedge clk);
      check("rst6_rescan_done", 64'(bus.scan_done), 64'd1);
      check("rst6_rescan_valid", 64'(bus.out_valid), 64'd0);
      $display("test6 reset mid-scan done");

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
